// File: rtl/ones_pattern_gen_pkg.sv
// Shared types and defaults for the ones-pattern generator.
// Optional self-check build: ONES_PATTERN_GEN_SELFCHECK_EN.
package ones_pattern_pkg;

    localparam int OUT_WIDTH_D = 8;
    localparam int CNT_WIDTH_D = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic int unsigned min_cnt(
        input int unsigned c,
        input int unsigned lim
    );
        return (c > lim) ? lim : c;
    endfunction

endpackage

// File: rtl/ones_pattern_gen_if.sv
// Count-in / word-out handshake bundle for the ones-pattern generator.
// The generator is the slave; its stimulus source/consumer is the master.
interface ones_pattern_gen_if
    import ones_pattern_pkg::*;
#(
    parameter int OUT_WIDTH = OUT_WIDTH_D,
    parameter int CNT_WIDTH = CNT_WIDTH_D
);
    logic                 cnt_valid;
    logic                 cnt_ready;
    logic [CNT_WIDTH-1:0] cnt_in;
    logic                 word_valid;
    logic                 word_ready;
    logic [OUT_WIDTH-1:0] word_out;

    modport master (
        output cnt_valid, cnt_in, word_ready,
        input  cnt_ready, word_valid, word_out
    );

    modport slave (
        input  cnt_valid, cnt_in, word_ready,
        output cnt_ready, word_valid, word_out
    );
endinterface

// File: rtl/ones_pattern_gen_pop_chk.sv
// Combinational popcount used to cross-check the generated word.
module ones_pop_chk
    import ones_pattern_pkg::*;
#(
    parameter int OUT_WIDTH = OUT_WIDTH_D,
    parameter int CNT_WIDTH = CNT_WIDTH_D
) (
    input  logic [OUT_WIDTH-1:0] word,
    output logic [CNT_WIDTH-1:0] pop
);
    always_comb begin
        pop = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            pop = pop + CNT_WIDTH'(word[i]);
        end
    end
endmodule

// File: rtl/ones_pattern_gen.sv
// Serial thermometer-code generator: count in, (1<<n)-1 word out.
// Define ONES_PATTERN_GEN_SELFCHECK_EN for the chk_err popcount check.
module ones_pattern_gen
    import ones_pattern_pkg::*;
#(
    parameter int OUT_WIDTH = OUT_WIDTH_D,
    parameter int CNT_WIDTH = CNT_WIDTH_D
) (
    input  logic                clk,
    input  logic                rst,
    ones_pattern_gen_if.slave   bus,
`ifdef ONES_PATTERN_GEN_SELFCHECK_EN
    output logic                chk_err,
`endif
    output logic                busy,
    output logic                sat
);
    localparam int IW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(OUT_WIDTH - 1);

    state_t               state;
    logic [CNT_WIDTH-1:0] idx;
    logic [CNT_WIDTH-1:0] count;
    logic [OUT_WIDTH-1:0] word_fill;

    // Word as it will look after the current FILL step lands.
    always_comb begin
        word_fill = bus.word_out;
        word_fill[idx[IW-1:0]] = (idx < count);
    end

`ifdef ONES_PATTERN_GEN_SELFCHECK_EN
    logic [OUT_WIDTH-1:0] pop_in;
    logic [CNT_WIDTH-1:0] pop;

    // On the last FILL edge check the finished word so chk_err is valid in HOLD's first cycle.
    assign pop_in = (state == FILL) ? word_fill : bus.word_out;

    ones_pop_chk #(
        .OUT_WIDTH (OUT_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_pop (
        .word (pop_in),
        .pop  (pop)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            count          <= '0;
            bus.word_out   <= '0;
            bus.cnt_ready  <= 1'b1;
            bus.word_valid <= 1'b0;
            busy           <= 1'b0;
            sat            <= 1'b0;
`ifdef ONES_PATTERN_GEN_SELFCHECK_EN
            chk_err        <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
`ifdef ONES_PATTERN_GEN_SELFCHECK_EN
                    chk_err <= 1'b0;
`endif
                    if (bus.cnt_valid && bus.cnt_ready) begin
                        count <= CNT_WIDTH'(min_cnt(32'(bus.cnt_in),
                                                    OUT_WIDTH));
                        sat           <= 32'(bus.cnt_in) > OUT_WIDTH;
                        bus.word_out  <= '0;
                        idx           <= '0;
                        bus.cnt_ready <= 1'b0;
                        busy          <= 1'b1;
                        state         <= FILL;
                    end
                end
                FILL: begin
                    bus.word_out <= word_fill;
                    if (idx == LAST) begin
                        bus.word_valid <= 1'b1;
                        state          <= HOLD;
                    end else begin
                        idx <= idx + 1'b1;
                    end
`ifdef ONES_PATTERN_GEN_SELFCHECK_EN
                    chk_err <= (idx == LAST) && (pop != count);
`endif
                end
                HOLD: begin
`ifdef ONES_PATTERN_GEN_SELFCHECK_EN
                    chk_err <= (pop != count);
`endif
                    if (bus.word_ready) begin
                        bus.word_valid <= 1'b0;
                        bus.cnt_ready  <= 1'b1;
                        busy           <= 1'b0;
                        state          <= IDLE;
`ifdef ONES_PATTERN_GEN_SELFCHECK_EN
                        chk_err        <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
